// File: rtl/event_serializer_pkg.sv
// event_serializer_pkg: shared state encoding, default gap length and transaction-length helper.
package event_serializer_pkg;
   typedef enum logic [2:0] {S_IDLE, S_BIT, S_GAP, S_ACT, S_CLR, S_FIN} state_t;
   localparam int DEF_GAP_CYCLES = 59_999;
   function automatic int txn_cycles(input int word_w, input int gap_cycles, input bit parity);
      return 2 + (word_w + int'(parity)) * (gap_cycles + 1);
   endfunction
endpackage

// File: rtl/event_serializer_gap_timer.sv
// gap_timer: loadable down-counter; zero flags the cycle whose decrement reaches 0.
module gap_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] cnt_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else if (load) cnt_q <= load_val;
      else if (dec && cnt_q != '0) cnt_q <= cnt_q - W'(1);
   assign zero = dec ? cnt_q <= W'(1) : cnt_q == '0;
endmodule

// File: rtl/event_serializer.sv
// event_serializer: replays a parallel word as spaced button-style events, MSB first.
// Define EVENT_SERIALIZER_PARITY_EN to append an even-parity bit before activity.
module event_serializer
   import event_serializer_pkg::*;
#(
   parameter int WORD_W     = 4,
   parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [WORD_W-1:0] data,
   input  logic              clear_req,
   output logic              logic0,
   output logic              logic1,
   output logic              activity,
   output logic              activity_reset,
   output logic              busy,
   output logic              done
);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam int BW = $clog2(WORD_W + 2);
`ifdef EVENT_SERIALIZER_PARITY_EN
   localparam int NB = WORD_W + 1;
`else
   localparam int NB = WORD_W;
`endif
   state_t            state_q, state_d;
   logic [WORD_W-1:0] shift_q;
   logic [BW-1:0]     bcnt_q;
   logic              shift_in, gap_zero, accept;
   assign accept = state_q == S_IDLE && start;
`ifdef EVENT_SERIALIZER_PARITY_EN
   // Parity is shifted in behind the data so it reaches the MSB after the last data bit.
   logic par_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) par_q <= 1'b0;
      else if (accept) par_q <= ^data;
   assign shift_in = par_q;
`else
   assign shift_in = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= S_IDLE;
      else state_q <= state_d;
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:       state_d = start ? S_BIT : clear_req ? S_CLR : S_IDLE;
         S_BIT:        state_d = S_GAP;
         S_GAP:        state_d = gap_zero ? (bcnt_q != '0 ? S_BIT : S_ACT) : S_GAP;
         S_ACT, S_CLR: state_d = S_FIN;
         default:      state_d = S_IDLE;
      endcase
   end
   always_comb begin
      logic1         = state_q == S_BIT && shift_q[WORD_W-1];
      logic0         = state_q == S_BIT && !shift_q[WORD_W-1];
      activity       = state_q == S_ACT;
      activity_reset = state_q == S_CLR;
      busy           = state_q inside {S_BIT, S_GAP, S_ACT, S_CLR};
      done           = state_q == S_FIN;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         shift_q <= '0;
         bcnt_q  <= '0;
      end else if (accept) begin
         shift_q <= data;
         bcnt_q  <= BW'(NB);
      end else if (state_q == S_BIT) begin
         shift_q <= (shift_q << 1) | WORD_W'(shift_in);
         bcnt_q  <= bcnt_q - BW'(1);
      end
   gap_timer #(.W(GW)) u_gap (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (state_q == S_BIT),
      .dec      (state_q == S_GAP),
      .load_val (GW'(GAP_CYCLES)),
      .zero     (gap_zero)
   );
endmodule

// File: tb/tb_event_serializer.sv
// tb_event_serializer: directed cycle-by-cycle checks of event_serializer (WORD_W=4, GAP_CYCLES=3).
module tb_event_serializer;
   import event_serializer_pkg::*;
   localparam int G = 3;
`ifdef EVENT_SERIALIZER_PARITY_EN
   localparam int NB = 5;
   localparam bit PAR = 1'b1;
`else
   localparam int NB = 4;
   localparam bit PAR = 1'b0;
`endif
   logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, clear_req = 1'b0;
   logic [3:0] data = '0;
   logic       logic0, logic1, activity, activity_reset, busy, done;
   int         n_vec = 0, n_err = 0;
   event_serializer #(.WORD_W(4), .GAP_CYCLES(G)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .data           (data),
      .clear_req      (clear_req),
      .logic0         (logic0),
      .logic1         (logic1),
      .activity       (activity),
      .activity_reset (activity_reset),
      .busy           (busy),
      .done           (done)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got {l0,l1,act,arst,busy,done}=%b exp %b", tag, got, exp);
      end
   endtask
   // Expected outputs r cycles after the accepted request, {l0,l1,act,arst,busy,done}.
   function automatic logic [5:0] model(input logic [NB-1:0] b, input bit data_mode, input int r);
      logic l0, l1;
      int   p, k;
      p = G + 1;
      l0 = 1'b0;
      l1 = 1'b0;
      if (!data_mode) return {2'b00, 1'b0, r == 1, r == 1, r == 2};
      if (r >= 1 && (r - 1) % p == 0 && (r - 1) / p < NB) begin
         k = (r - 1) / p;
         l1 = b[NB-1-k];
         l0 = !b[NB-1-k];
      end
      return {l0, l1, r == 1 + NB * p, 1'b0, r >= 1 && r <= 1 + NB * p, r == 2 + NB * p};
   endfunction
   task automatic run(input string tag, input logic [3:0] d, input bit st, input bit clr,
                      input int re_c, input int rst_c, input int ncyc);
      logic [NB-1:0] bits;
      logic [5:0]    e;
      int            o;
      bit            fresh;
`ifdef EVENT_SERIALIZER_PARITY_EN
      bits = {d, ^d};
`else
      bits = d;
`endif
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         fresh     = rst_c >= 0 && c == rst_c + 3;
         start     = (c == 0 && st) || c == re_c || fresh;
         clear_req = (c == 0 && clr) || c == re_c;
         data      = (c == 0 || fresh) ? d : ~d;
         rst_n     = !(rst_c >= 0 && c >= rst_c && c < rst_c + 2);
         #1;
         o = (rst_c >= 0 && c >= rst_c + 3) ? rst_c + 3 : 0;
         e = (rst_c >= 0 && c >= rst_c && c < rst_c + 3) ? 6'b0 : model(bits, st || fresh, c - o);
         check($sformatf("%s c%0d", tag, c), {logic0, logic1, activity, activity_reset, busy, done}, e);
      end
      start     = 1'b0;
      clear_req = 1'b0;
   endtask
   initial begin
      int dn;
      dn = txn_cycles(4, G, PAR);
      @(negedge clk);
      #1;
      check("reset", {logic0, logic1, activity, activity_reset, busy, done}, 6'b0);
      rst_n = 1'b1;
      run("w1010",        4'b1010, 1, 0, -1, -1, dn + 3);
      run("clear",        4'b0000, 0, 1, -1, -1, 6);
      run("both_1111",    4'b1111, 1, 1, -1, -1, dn + 3);
      run("busy_restart", 4'b1010, 1, 0,  6, -1, dn + 3);
      run("fin_restart",  4'b0110, 1, 0, dn, -1, dn + 4);
      run("mid_reset",    4'b1010, 1, 0, -1,  7, dn + 13);
      run("w1011",        4'b1011, 1, 0, -1, -1, dn + 3);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
